// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: fill / butterfly / hold / drain around a D-deep delay line.
// Latency: every output is registered, so the response to a sample accepted at edge t shows in cycle t+1.
// Backpressure: in_ready is low only while draining; stalls (in_valid=0) freeze the position counter.
module fft_sdf_stage_ctrl #(
  parameter int LAYER    = 11,
  parameter int TW_BITS  = 10,
  parameter int TW_SHIFT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic               flush,
  output logic               in_ready,
  output logic               bf_sel,
  output logic               dly_wea,
  output logic [TW_BITS-1:0] tw_addr,
  output logic               out_valid,
  output logic               out_first,
  output logic               out_last,
  output logic               busy,
  output logic               err_sync
);

  // Counter spans one half-frame (D samples); LAYER must be at least 2.
  localparam int CW = LAYER - 1;
  localparam int WW = (CW + TW_SHIFT > TW_BITS) ? (CW + TW_SHIFT) : TW_BITS;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [2:0] {IDLE, FILL, BFLY, HOLD, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 in_ready_q, in_ready_d;
  logic                 bf_sel_q, bf_sel_d;
  logic                 dly_wea_q, dly_wea_d;
  logic [TW_BITS-1:0]   tw_addr_q, tw_addr_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_first_q, out_first_d;
  logic                 out_last_q, out_last_d;
  logic                 busy_q, busy_d;
  logic                 err_sync_q, err_sync_d;

  logic                 acc;
  logic                 cnt_last;
  logic [WW-1:0]        tw_wide;

  assign acc      = in_valid && in_ready_q;
  assign cnt_last = (cnt_q == CNT_MAX);
  // Shared-ROM stride; the upper bits fall off when truncated to TW_BITS.
  assign tw_wide  = WW'(cnt_q) << TW_SHIFT;

  // Next-state and next-output decode; bf_sel/tw_addr hold through stalls.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    bf_sel_d    = bf_sel_q;
    tw_addr_d   = tw_addr_q;
    dly_wea_d   = 1'b0;
    out_valid_d = 1'b0;
    out_first_d = 1'b0;
    out_last_d  = 1'b0;
    err_sync_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc && in_first) begin
          state_d   = FILL;
          cnt_d     = CNT_ONE;
          pend_d    = 1'b0;
          dly_wea_d = 1'b1;
          bf_sel_d  = 1'b0;
          tw_addr_d = '0;
        end
      end
      FILL, BFLY: begin
        if (acc) begin
          dly_wea_d = 1'b1;
          if (in_first) begin
            // Frame start seen mid-frame: realign and forget the stored differences.
            err_sync_d = 1'b1;
            state_d    = FILL;
            cnt_d      = CNT_ONE;
            pend_d     = 1'b0;
            bf_sel_d   = 1'b0;
            tw_addr_d  = '0;
          end else if (state_q == FILL) begin
            bf_sel_d    = 1'b0;
            tw_addr_d   = '0;
            out_valid_d = pend_q;
            out_last_d  = pend_q && cnt_last;
            if (cnt_last) begin
              state_d = BFLY;
              cnt_d   = '0;
              pend_d  = 1'b0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            bf_sel_d    = 1'b1;
            tw_addr_d   = tw_wide[TW_BITS-1:0];
            out_valid_d = 1'b1;
            out_first_d = (cnt_q == '0);
            if (cnt_last) begin
              state_d = HOLD;
              cnt_d   = '0;
              pend_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
      end
      HOLD: begin
        if (acc && in_first) begin
          // Next frame starts; its fill phase streams out the held differences.
          state_d     = FILL;
          cnt_d       = CNT_ONE;
          dly_wea_d   = 1'b1;
          out_valid_d = pend_q;
          bf_sel_d    = 1'b0;
          tw_addr_d   = '0;
        end else begin
          err_sync_d = acc;
          if (flush) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end
      DRAIN: begin
        out_valid_d = 1'b1;
        dly_wea_d   = 1'b1;
        bf_sel_d    = 1'b0;
        tw_addr_d   = '0;
        if (cnt_last) begin
          state_d    = IDLE;
          cnt_d      = '0;
          pend_d     = 1'b0;
          out_last_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d     = (state_q != IDLE);
    in_ready_d = (state_d != DRAIN);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      bf_sel_q    <= 1'b0;
      dly_wea_q   <= 1'b0;
      tw_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_sync_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      in_ready_q  <= in_ready_d;
      bf_sel_q    <= bf_sel_d;
      dly_wea_q   <= dly_wea_d;
      tw_addr_q   <= tw_addr_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      err_sync_q  <= err_sync_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign bf_sel    = bf_sel_q;
  assign dly_wea   = dly_wea_q;
  assign tw_addr   = tw_addr_q;
  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign err_sync  = err_sync_q;

endmodule

// File: doc/fft_sdf_stage_ctrl.md
# fft_sdf_stage_ctrl

Sequencer for one radix-2 single-path delay-feedback (SDF) FFT stage built around the RAM delay line of length D = 2^(LAYER-1). It tracks sample position within each frame, drives the butterfly select, delay-line write enable and twiddle ROM address, and produces output framing flags. It also flushes the stored differences after the last frame. One instance sits beside each stage's delay line and butterfly; stages chain through out_valid/out_first.

## Interface
- LAYER, 11, stage index; D = 2^(LAYER-1) samples, frame = 2·D samples
- TW_BITS, 10, twiddle ROM address width
- TW_SHIFT, 0, left shift applied to the butterfly index for tw_addr (stride for shared ROM)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  input sample strobe
- in_first  in  1  qualifies in_valid: sample 0 of a frame
- flush  in  1  one-cycle request to drain pending differences
- in_ready  out  1  sample accepted when in_valid && in_ready
- bf_sel  out  1  0: pass input into delay and emit delay output; 1: butterfly
- dly_wea  out  1  delay-line write strobe, one per accepted sample or drain cycle
- tw_addr  out  TW_BITS  twiddle address
- out_valid  out  1  stage output sample strobe
- out_first  out  1  first output of a frame (first sum)
- out_last  out  1  last output of a frame (last difference)
- busy  out  1  state != IDLE
- err_sync  out  1  one-cycle pulse on frame misalignment

## Operation
- Counter cnt, LAYER-1 bits, counts accepted samples within the current half-frame; flag pend = differences of previous frame held in delay line.
- States: IDLE, FILL, BFLY, HOLD, DRAIN.
- IDLE: accepted sample with in_first -> FILL, cnt=1, pend=0. Samples without in_first dropped silently.
- FILL: bf_sel=0. Each accepted sample cnt++; out_valid=pend (difference of previous frame emitted). At cnt==D-1 accepted -> BFLY, cnt=0, pend cleared.
- BFLY: bf_sel=1, tw_addr=(cnt<<TW_SHIFT) truncated to TW_BITS; out_valid per accepted sample (sums). At cnt==D-1 accepted -> HOLD, pend=1.
- HOLD: accepted sample with in_first -> FILL, cnt=1, pend stays 1 (that sample's out_valid=1). Accepted sample without in_first -> err_sync, dropped, stay HOLD. flush -> DRAIN, cnt=0.
- DRAIN: in_ready=0; every cycle out_valid=1, dly_wea=1, bf_sel=0, cnt++; at cnt==D-1 -> IDLE, pend=0.
- in_first accepted in FILL/BFLY with position != 0: err_sync pulse, frame restarts as FILL cnt=1, pend=0.
- flush outside HOLD ignored. in_ready=1 in all states except DRAIN.
- Stalls (in_valid=0) in FILL/BFLY/HOLD: counters hold, dly_wea=0, out_valid=0.
- out_first: first accepted BFLY sample. out_last: last pending difference (FILL cnt==D-1 with pend, or final DRAIN cycle).

## Timing
- All outputs registered; response to a sample accepted at edge t appears in cycle t+1, aligned with the delay-line address of that sample.
- Reset (including mid-frame): next cycle state IDLE, cnt=0, pend=0; bf_sel, dly_wea, tw_addr, out_valid, out_first, out_last, busy, err_sync = 0; in_ready=1.
- Back-to-back frames: no bubble; last BFLY sample at t, in_first sample accepted at t+1 in HOLD.
- DRAIN length exactly D cycles; busy falls the cycle after the last DRAIN output.
- in_first and flush together in HOLD: sample wins, flush ignored.
- cnt wraps only by state transition; tw_addr wrap by truncation is allowed.

## Test plan
- LAYER=3 (D=4), one 8-sample frame, continuous valid, then flush -> bf_sel 0,0,0,0,1,1,1,1; tw_addr 0,1,2,3 in BFLY; 4 sums then 4 DRAIN outputs, out_first on output 1, out_last on output 8, busy low after.
- Two back-to-back frames, D=4 -> 16 contiguous in_valid produce 12 out_valid before flush; frame-2 FILL outputs flagged as frame-1 differences, out_last on 4th.
- Stall: in_valid low 3 cycles mid-BFLY -> cnt, tw_addr hold, no out_valid or dly_wea during gap.
- Misalignment: in_first at FILL cnt=2 -> err_sync one cycle, restart FILL cnt=1, pend=0, no out_valid.
- TW_SHIFT=2, TW_BITS=3, D=4 -> tw_addr 0,4,0,4 (truncated).
- rst asserted in DRAIN cycle 2 -> next cycle all outputs 0, in_ready=1, IDLE; following frame runs normally.
